stepper_move_scheduler: RTL and testbench
=========================================

Name: stepper_move_scheduler

Overview:
Sequences queued stepper-motor moves and drives the 4-phase coil outputs directly.
Each command carries a 2-bit direction/mode code and a 2-bit duration code. Commands come from a random-number mapper, a host or a test pattern, and enter a small FIFO through a valid/ready handshake.
The block paces steps with a clock divider, walks a half-step phase table and inserts a dwell between moves. It reports completion and occupancy.

Parameters:
CLK_DIV, 100000, clk cycles per step period (>=2)
STEPS_UNIT, 512, steps per duration unit; move length = (cmd_dur+1)*STEPS_UNIT
DWELL, 4, idle step periods after each move, with coils held (>=1)
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock; all state is on its rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_dir  in  2  00 hold, 01 forward full-step, 10 reverse full-step, 11 forward half-step
cmd_dur  in  2  duration code 0..3
enable  in  1  0 pauses the divider and blocks command pop; FIFO still accepts pushes
flush  in  1  synchronous; aborts the move and empties the FIFO
phases  out  4  coil drive {A,B,C,D}
busy  out  1  1 in any state except IDLE
move_done  out  1  one-cycle pulse at the end of each completed move
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued commands

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE, FIFO empty, phase index idx=1.
  - phases=0000, busy=0, move_done=0, cmd_ready=1, fifo_count=0.
- Push: when cmd_valid && cmd_ready, {dir,dur} is written; fifo_count updates on the next cycle.
  - No push occurs when full.
  - A push and a pop in the same cycle leave the count unchanged.
- Phase table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - idx persists across moves; it is not reset by flush.
- FSM states: IDLE, LOAD, STEP, DWELL.
- IDLE:
  - phases=0000.
  - If enable && fifo_count!=0 → LOAD.
- LOAD (exactly 1 cycle):
  - Pop the head entry.
  - steps_left = (dur+1)*STEPS_UNIT; div = CLK_DIV-1.
  - For full-step modes with even idx, idx += 1 (align to two-coil entries).
  - phases = table[idx] from this cycle on.
  - → STEP.
- STEP:
  - When enable=1, div decrements; when enable=0, div holds.
  - On div==0 (a step edge):
    - Advance idx: +2 for 01, -2 for 10, +1 for 11, unchanged for 00. Wrap mod 8.
    - steps_left -= 1; div reloads to CLK_DIV-1.
  - When the step edge takes steps_left to 0 → DWELL, with move_done=1 in that same cycle.
  - The first step edge is CLK_DIV enabled cycles after LOAD.
- DWELL:
  - phases holds table[idx]; counter loads DWELL*CLK_DIV-1 and decrements while enable=1.
  - At 0 → IDLE.
- flush: takes priority over all other events.
  - Next cycle: FSM=IDLE, FIFO empty, phases=0000, move_done=0.
  - A push in the flush cycle is discarded.
- Reset asserted mid-move: immediate return to reset values, regardless of clk.
- Widths:
  - steps_left is $clog2(4*STEPS_UNIT+1) bits.
  - The dwell counter is $clog2(DWELL*CLK_DIV) bits.
  - Every counter is unsigned with no overflow path.

Decomposition:
- Package stepper_pkg holds:
  - the state enum (IDLE/LOAD/STEP/DWELL);
  - the dir localparams (DIR_HOLD=2'b00, DIR_FWD=2'b01, DIR_REV=2'b10, DIR_HALF=2'b11);
  - the 8-entry phase table constant;
  - the cmd_t struct {dir,dur}.
- One sub-module, stepper_cmd_fifo: parameterized synchronous FIFO with push/pop/flush/count.

Test Plan:
Test parameters are CLK_DIV=4, STEPS_UNIT=2, DWELL=1, FIFO_DEPTH=4.
1. Reset, then idle 10 cycles:
   - phases=0000, busy=0, cmd_ready=1, fifo_count=0 throughout.
2. Push {dir=01,dur=00} with enable=1:
   - LOAD drives 1100; after 4 cycles 0110; after 4 more 0011, together with a one-cycle move_done.
   - 4 cycles of DWELL hold 0011; then phases=0000, busy=0.
3. With enable=0, offer 5 back-to-back commands:
   - First 4 accepted; cmd_ready=0 after the 4th; fifo_count=4; the 5th is not accepted.
   - Raise enable: 4 moves with 4 move_done pulses; fifo_count ends at 0.
4. Starting from idx=3, push {dir=11,dur=00}:
   - Patterns 0110 → 0010 → 0011.
   - Then push {dir=10,dur=00}: 0011 → 0110 → 1100.
5. Assert flush mid-STEP with 2 entries queued:
   - Next cycle phases=0000, busy=0, fifo_count=0; no move_done.
6. Drop enable for 7 cycles mid-STEP:
   - phases and div freeze; the step edge arrives exactly 7 cycles late; step count unchanged.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move scheduler: FSM states,
// direction codes, half-step coil table and the queued command format.
package stepper_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STEP, ST_DWELL} state_e;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;
  localparam logic [1:0] DIR_HALF = 2'b11;

  // Index 0 is the rightmost element: {A,B,C,D} half-step sequence.
  localparam logic [7:0][3:0] PHASE_TBL = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  typedef struct packed {
    logic [1:0] dir;
    logic [1:0] dur;
  } cmd_t;
endpackage

// File: rtl/stepper_move_scheduler_fifo.sv
// Small first-word-fall-through command FIFO; flush empties it and wins over
// a same-cycle push or pop.
module stepper_cmd_fifo
  import stepper_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_push,
  input  cmd_t        i_din,
  input  logic        i_pop,
  input  logic        i_flush,
  output cmd_t        o_dout,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);
  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/stepper_move_scheduler.sv
// Pulls moves from the command FIFO, paces steps with a clock divider, walks
// the half-step coil table and dwells with coils held between moves.
module stepper_move_scheduler
  import stepper_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int STEPS_UNIT = 512,
  parameter int DWELL      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_dir,
  input  logic [1:0]                    cmd_dur,
  input  logic                          enable,
  input  logic                          flush,
  output logic [3:0]                    phases,
  output logic                          busy,
  output logic                          move_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int SW   = $clog2(4*STEPS_UNIT+1);
  localparam int DWW  = $clog2(DWELL*CLK_DIV);
  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLK_DIV-1);
  localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL*CLK_DIV-1);

  state_e          r_state, w_next;
  logic [2:0]      r_idx, w_load_idx, w_delta;
  logic [SW-1:0]   r_steps;
  logic [DIVW-1:0] r_div;
  logic [DWW-1:0]  r_dwell;
  logic [1:0]      r_mode;
  logic            r_done;
  logic            w_edge, w_last_step, w_full, w_empty;
  cmd_t            w_head, w_din;

  assign w_din = '{dir: cmd_dir, dur: cmd_dur};

  stepper_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (cmd_valid),
    .i_din   (w_din),
    .i_pop   (r_state == ST_LOAD),
    .i_flush (flush),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Full-step moves must start on a two-coil (odd) table entry.
  assign w_load_idx  = ((w_head.dir == DIR_FWD || w_head.dir == DIR_REV) && !r_idx[0])
                       ? r_idx + 3'd1 : r_idx;
  assign w_edge      = (r_state == ST_STEP) && enable && (r_div == '0);
  assign w_last_step = (r_steps == SW'(1));

  always_comb begin
    w_delta = 3'd0;
    case (r_mode)
      DIR_FWD:  w_delta = 3'd2;
      DIR_REV:  w_delta = 3'd6;
      DIR_HALF: w_delta = 3'd1;
      default:  w_delta = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    phases = PHASE_TBL[r_idx];
    unique case (r_state)
      ST_IDLE: begin
        phases = 4'b0000;
        if (enable && !w_empty) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        phases = PHASE_TBL[w_load_idx];
        w_next = ST_STEP;
      end
      ST_STEP:  if (w_edge && w_last_step) w_next = ST_DWELL;
      ST_DWELL: if (enable && r_dwell == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= 3'd1;
      r_steps <= '0;
      r_div   <= '0;
      r_dwell <= '0;
      r_mode  <= DIR_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_done <= !flush && w_edge && w_last_step;
      if (!flush) begin
        unique case (r_state)
          ST_LOAD: begin
            r_idx   <= w_load_idx;
            r_mode  <= w_head.dir;
            r_steps <= SW'((int'(w_head.dur) + 1) * STEPS_UNIT);
            r_div   <= DIV_LAST;
          end
          ST_STEP: if (enable) begin
            if (r_div == '0) begin
              r_idx   <= r_idx + w_delta;
              r_steps <= r_steps - 1'b1;
              r_div   <= DIV_LAST;
              if (w_last_step) r_dwell <= DWELL_LAST;
            end else begin
              r_div <= r_div - 1'b1;
            end
          end
          ST_DWELL: if (enable && r_dwell != '0) r_dwell <= r_dwell - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign move_done = r_done;
  assign cmd_ready = !w_full;
endmodule

// File: tb/tb_stepper_move_scheduler.sv
// Directed plus randomized bench; each move's coil trace is predicted from
// table position arithmetic on enabled step-period counts.
module tb_stepper_move_scheduler;
  localparam int CD = 4, SU = 2, DW = 1, FD = 4;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       cmd_valid = 1'b0, enable = 1'b1, flush = 1'b0;
  logic [1:0] cmd_dir = 2'b00, cmd_dur = 2'b00;
  logic       cmd_ready, busy, move_done;
  logic [3:0] phases;
  logic [2:0] fifo_count;

  stepper_move_scheduler #(.CLK_DIV(CD), .STEPS_UNIT(SU), .DWELL(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_dur(cmd_dur), .enable(enable), .flush(flush),
    .phases(phases), .busy(busy), .move_done(move_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  logic [3:0] TBL [8];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_idx = 1;
  logic [1:0] q_dir [$];
  logic [1:0] q_dur [$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] u);
    cmd_valid = 1'b1; cmd_dir = d; cmd_dur = u;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Observes one move from LOAD through the first IDLE cycle after dwell.
  // Enable is dropped for pl STEP cycles starting at STEP cycle pk.
  task automatic run_move(input logic [1:0] dir, input logic [1:0] dur, input int pk, input int pl);
    int s, d, ia, en, cyc, fin;
    s  = (int'(dur) + 1) * SU;
    d  = (dir == 2'b01) ? 2 : (dir == 2'b10) ? 6 : (dir == 2'b11) ? 1 : 0;
    ia = ((dir == 2'b01 || dir == 2'b10) && (m_idx % 2 == 0)) ? m_idx + 1 : m_idx;
    fin = (ia + d * s) % 8;
    tick();
    chk("load_ph", 32'(phases), 32'(TBL[ia]));
    chk("load_busy", 32'(busy), 32'd1);
    tick();
    en = 0; cyc = 0;
    while (en < s * CD) begin
      chk($sformatf("step_ph c%0d", cyc), 32'(phases), 32'(TBL[(ia + d * (en / CD)) % 8]));
      chk("step_done", 32'(move_done), 32'd0);
      enable = (cyc >= pk && cyc < pk + pl) ? 1'b0 : 1'b1;
      if (enable) en++;
      cyc++;
      tick();
    end
    enable = 1'b1;
    for (int j = 0; j < DW * CD; j++) begin
      chk($sformatf("dwell_ph %0d", j), 32'(phases), 32'(TBL[fin]));
      chk($sformatf("dwell_done %0d", j), 32'(move_done), 32'(j == 0));
      chk("dwell_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("end_ph", 32'(phases), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(move_done), 32'd0);
    m_idx = fin;
  endtask

  initial begin
    TBL = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // reset and idle
    repeat (2) tick();
    chk("rst_ph", 32'(phases), 32'd0);
    chk("rst_rdy", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ph", 32'(phases), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rdy", 32'(cmd_ready), 32'd1);
      chk("idle_cnt", 32'(fifo_count), 32'd0);
    end

    // single forward full-step move
    push(2'b01, 2'b00);
    run_move(2'b01, 2'b00, 0, 0);

    // fill the FIFO while paused; fifth offer must be refused
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] d, u;
      d = 2'($urandom_range(0, 3)); u = 2'($urandom_range(0, 1));
      chk($sformatf("fill_rdy %0d", i), 32'(cmd_ready), 32'(i < 4));
      chk($sformatf("fill_cnt %0d", i), 32'(fifo_count), 32'(i));
      if (i < 4) begin q_dir.push_back(d); q_dur.push_back(u); end
      cmd_valid = 1'b1; cmd_dir = d; cmd_dur = u;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    chk("full_cnt", 32'(fifo_count), 32'd4);
    chk("full_rdy", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    while (q_dir.size() > 0) run_move(q_dir.pop_front(), q_dur.pop_front(), 0, 0);
    chk("drain_cnt", 32'(fifo_count), 32'd0);

    // asynchronous reset mid-move
    push(2'b01, 2'b11);
    repeat (6) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ph", 32'(phases), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(move_done), 32'd0);
    chk("arst_cnt", 32'(fifo_count), 32'd0);
    chk("arst_rdy", 32'(cmd_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    m_idx = 1;

    // half-step to idx 3, then half-step and reverse from there
    push(2'b11, 2'b00);
    run_move(2'b11, 2'b00, 0, 0);
    chk("idx3", 32'(m_idx), 32'd3);
    push(2'b11, 2'b00);
    run_move(2'b11, 2'b00, 0, 0);
    push(2'b10, 2'b00);
    run_move(2'b10, 2'b00, 0, 0);

    // flush mid-STEP with two entries still queued
    enable = 1'b0;
    push(2'b01, 2'b01); push(2'b10, 2'b00); push(2'b11, 2'b01);
    enable = 1'b1;
    tick();
    m_idx = (m_idx % 2 == 0) ? m_idx + 1 : m_idx;
    chk("fl_load", 32'(phases), 32'(TBL[m_idx]));
    tick(); tick();
    chk("fl_cnt_pre", 32'(fifo_count), 32'd2);
    flush = 1'b1; cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_dur = 2'b00;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    chk("fl_ph", 32'(phases), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_cnt", 32'(fifo_count), 32'd0);
    chk("fl_done", 32'(move_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_idle_busy", 32'(busy), 32'd0);
      chk("fl_idle_done", 32'(move_done), 32'd0);
    end

    // enable dropped for 7 cycles mid-STEP
    push(2'b01, 2'b01);
    run_move(2'b01, 2'b01, 5, 7);

    // randomized moves with random pauses
    for (int r = 0; r < 8; r++) begin
      logic [1:0] d, u;
      d = 2'($urandom_range(0, 3)); u = 2'($urandom_range(0, 3));
      push(d, u);
      run_move(d, u, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
